// File: rtl/symbol_packer_pkg.sv
// Shared types for the symbol packer: symbol width, symbol type and the
// accumulator FSM encoding.
package symbol_packer_pkg;
   localparam int SYM_W         = 2;
   localparam int SYMS_PER_WORD = 4;
   localparam int CNT_W         = 8;

   typedef logic [SYM_W-1:0] sym_t;

   typedef enum logic {
      ACC_EMPTY,
      ACC_PARTIAL
   } acc_state_t;
endpackage

// File: rtl/symbol_packer_word_out_reg.sv
// One-entry valid/ready holding register. A load into an occupied entry that
// is not draining on the same edge is dropped and latches a sticky overflow.
module word_out_reg #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic              ready_i,
   output logic [WORD_W-1:0] word_o,
   output logic              valid_o,
   output logic              overflow_o,
   output logic [CNT_W-1:0]  count_o
);
   logic [WORD_W-1:0] word_q, word_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              deliver;

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      deliver = valid_q && ready_i;
      if (deliver) begin
         valid_d = 1'b0;
         cnt_d   = cnt_q + 1'b1;
      end
      // A drain on the same edge frees the entry, so back-to-back words never bubble.
      if (load_i) begin
         if (!valid_q || deliver) begin
            word_d  = word_i;
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   assign word_o     = word_q;
   assign valid_o    = valid_q;
   assign overflow_o = ovf_q;
   assign count_o    = cnt_q;
endmodule

// File: rtl/symbol_packer.sv
// Packs detector symbols LSB-first into words and hands them to a one-entry
// output register. Intake is never stalled.
//   state       | meaning
//   ACC_EMPTY   | slot == 0, accumulator clear
//   ACC_PARTIAL | 0 < slot < SYMS_PER_WORD
module symbol_packer #(
   parameter int SYM_W         = symbol_packer_pkg::SYM_W,
   parameter int SYMS_PER_WORD = symbol_packer_pkg::SYMS_PER_WORD,
   parameter int CNT_W         = symbol_packer_pkg::CNT_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [SYM_W-1:0]               sym_in,
   input  logic                           sym_valid,
   input  logic                           flush,
   output logic [SYM_W*SYMS_PER_WORD-1:0] word_out,
   output logic                           word_valid,
   input  logic                           word_ready,
   output logic                           overflow,
   output logic [CNT_W-1:0]               word_count
);
   import symbol_packer_pkg::*;

   localparam int WORD_W = SYM_W * SYMS_PER_WORD;
   localparam int SLOT_W = $clog2(SYMS_PER_WORD);
   localparam logic [SLOT_W:0] FULL = (SLOT_W+1)'(SYMS_PER_WORD);

   acc_state_t        state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [WORD_W-1:0] acc_q, acc_d, acc_eff;
   logic [SLOT_W:0]   slot_eff;
   logic              done;
   int                idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ACC_EMPTY;
         slot_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      acc_eff  = acc_q;
      slot_eff = {1'b0, slot_q};
      idx      = int'(slot_q) * SYM_W;
      if (sym_valid) begin
         acc_eff[idx +: SYM_W] = sym_in;
         slot_eff              = slot_eff + 1'b1;
      end
      // Unfilled positions are already zero because the accumulator clears on every completion.
      done    = (slot_eff == FULL) || (flush && (state_q == ACC_PARTIAL || sym_valid));
      acc_d   = done ? '0 : acc_eff;
      slot_d  = done ? '0 : slot_eff[SLOT_W-1:0];
      state_d = (slot_d == '0) ? ACC_EMPTY : ACC_PARTIAL;
   end

   word_out_reg #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) u_word_out_reg (
      .clk        (clk),
      .reset      (reset),
      .load_i     (done),
      .word_i     (acc_eff),
      .ready_i    (word_ready),
      .word_o     (word_out),
      .valid_o    (word_valid),
      .overflow_o (overflow),
      .count_o    (word_count)
   );
endmodule

// File: tb/tb_symbol_packer.sv
// Directed-vector bench for symbol_packer at default parameters.
module tb_symbol_packer;
   logic       clk = 1'b0;
   logic       reset, sym_valid, flush, word_ready;
   logic [1:0] sym_in;
   logic [7:0] word_out;
   logic       word_valid, overflow;
   logic [7:0] word_count;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       rst;
      logic       sv;
      logic [1:0] sym;
      logic       fl;
      logic       rdy;
      logic [7:0] w;
      logic       v;
      logic       o;
      logic [7:0] c;
   } vec_t;

   vec_t vecs[$];

   symbol_packer dut (
      .clk        (clk),
      .reset      (reset),
      .sym_in     (sym_in),
      .sym_valid  (sym_valid),
      .flush      (flush),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .overflow   (overflow),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic sv, input logic [1:0] s, input logic f, input logic rd,
                      input logic [7:0] w, input logic v, input logic o, input logic [7:0] c);
      vec_t t;
      t.rst = r; t.sv = sv; t.sym = s; t.fl = f; t.rdy = rd;
      t.w = w; t.v = v; t.o = o; t.c = c;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic r, input logic sv, input logic [1:0] s, input logic f, input logic rd);
      @(negedge clk);
      reset = r; sym_valid = sv; sym_in = s; flush = f; word_ready = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; sym_valid = 1'b0; sym_in = 2'd0; flush = 1'b0; word_ready = 1'b0;

      //   rst sv sym fl rdy | word   v  o  count
      // single word 01,10,11,00 -> 0x39
      add(1, 0, 0, 0, 0,  8'h00, 0, 0, 8'd0);
      add(0, 1, 1, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 2, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 3, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 0, 0, 1,  8'h39, 1, 0, 8'd0);
      add(0, 0, 0, 0, 1,  8'h39, 0, 0, 8'd1);
      // two words 0x39, 0xFF
      add(1, 0, 0, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 1, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 2, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 3, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 0, 0, 1,  8'h39, 1, 0, 8'd0);
      add(0, 1, 3, 0, 1,  8'h39, 0, 0, 8'd1);
      add(0, 1, 3, 0, 1,  8'h39, 0, 0, 8'd1);
      add(0, 1, 3, 0, 1,  8'h39, 0, 0, 8'd1);
      add(0, 1, 3, 0, 1,  8'hFF, 1, 0, 8'd1);
      add(0, 0, 0, 0, 1,  8'hFF, 0, 0, 8'd2);
      // ready low: second word dropped, overflow sticky
      add(1, 0, 0, 0, 0,  8'h00, 0, 0, 8'd0);
      add(0, 1, 3, 0, 0,  8'h00, 0, 0, 8'd0);
      add(0, 1, 3, 0, 0,  8'h00, 0, 0, 8'd0);
      add(0, 1, 3, 0, 0,  8'h00, 0, 0, 8'd0);
      add(0, 1, 3, 0, 0,  8'hFF, 1, 0, 8'd0);
      add(0, 1, 3, 0, 0,  8'hFF, 1, 0, 8'd0);
      add(0, 1, 3, 0, 0,  8'hFF, 1, 0, 8'd0);
      add(0, 1, 3, 0, 0,  8'hFF, 1, 0, 8'd0);
      add(0, 1, 3, 0, 0,  8'hFF, 1, 1, 8'd0);
      add(0, 0, 0, 0, 1,  8'hFF, 0, 1, 8'd1);
      add(0, 0, 0, 0, 1,  8'hFF, 0, 1, 8'd1);
      // flush partial words
      add(1, 0, 0, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 3, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 1, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 0, 0, 1, 1,  8'h07, 1, 0, 8'd0);
      add(0, 1, 3, 0, 1,  8'h07, 0, 0, 8'd1);
      add(0, 1, 2, 1, 1,  8'h0B, 1, 0, 8'd1);
      add(0, 0, 0, 1, 1,  8'h0B, 0, 0, 8'd2);
      add(0, 0, 0, 0, 1,  8'h0B, 0, 0, 8'd2);
      // reset mid-fill, reset beats a same-cycle symbol
      add(0, 1, 3, 0, 1,  8'h0B, 0, 0, 8'd2);
      add(0, 1, 3, 0, 1,  8'h0B, 0, 0, 8'd2);
      add(0, 1, 3, 0, 1,  8'h0B, 0, 0, 8'd2);
      add(1, 1, 3, 1, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 0, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 0, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 0, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 1, 1, 0, 1,  8'h40, 1, 0, 8'd0);
      add(0, 0, 0, 0, 1,  8'h40, 0, 0, 8'd1);
      // flush coincident with natural completion -> one word
      add(0, 1, 1, 0, 1,  8'h40, 0, 0, 8'd1);
      add(0, 1, 1, 0, 1,  8'h40, 0, 0, 8'd1);
      add(0, 1, 1, 0, 1,  8'h40, 0, 0, 8'd1);
      add(0, 1, 1, 1, 1,  8'h55, 1, 0, 8'd1);
      add(0, 0, 0, 0, 1,  8'h55, 0, 0, 8'd2);
      add(0, 0, 0, 1, 1,  8'h55, 0, 0, 8'd2);
      // completion and delivery on the same edge: no overflow
      add(0, 1, 2, 0, 0,  8'h55, 0, 0, 8'd2);
      add(0, 1, 2, 0, 0,  8'h55, 0, 0, 8'd2);
      add(0, 1, 2, 0, 0,  8'h55, 0, 0, 8'd2);
      add(0, 1, 2, 0, 0,  8'hAA, 1, 0, 8'd2);
      add(0, 1, 0, 0, 0,  8'hAA, 1, 0, 8'd2);
      add(0, 1, 0, 0, 0,  8'hAA, 1, 0, 8'd2);
      add(0, 1, 0, 0, 0,  8'hAA, 1, 0, 8'd2);
      add(0, 1, 3, 0, 1,  8'hC0, 1, 0, 8'd3);
      add(0, 0, 0, 0, 1,  8'hC0, 0, 0, 8'd4);
      // reset while a word is held discards it
      add(0, 1, 1, 1, 0,  8'h01, 1, 0, 8'd4);
      add(1, 0, 0, 0, 1,  8'h00, 0, 0, 8'd0);
      add(0, 0, 0, 0, 1,  8'h00, 0, 0, 8'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].sv, vecs[i].sym, vecs[i].fl, vecs[i].rdy);
         check("word_out",   i, 32'(word_out),   32'(vecs[i].w));
         check("word_valid", i, 32'(word_valid), 32'(vecs[i].v));
         check("overflow",   i, 32'(overflow),   32'(vecs[i].o));
         check("word_count", i, 32'(word_count), 32'(vecs[i].c));
      end

      // Counter wrap: one flushed word per cycle, each delivered on the next edge.
      drive(1, 0, 0, 0, 1);
      for (int n = 1; n <= 257; n++) begin
         drive(0, 1, 2, 1, 1);
         if (n == 256) check("count_255", n, 32'(word_count), 32'd255);
      end
      check("wrap_count", 257, 32'(word_count), 32'd0);
      check("wrap_valid", 257, 32'(word_valid), 32'd1);
      check("wrap_word",  257, 32'(word_out),   32'h02);
      check("wrap_ovf",   257, 32'(overflow),   32'd0);
      drive(0, 0, 0, 0, 1);
      check("count_257",  258, 32'(word_count), 32'd1);
      check("drain_valid", 258, 32'(word_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
